// File: rtl/arr_port_if.sv
// arr_port_if: requester-side bus of the array port arbiter, one packed slot per requester.
interface arr_port_if #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 1,
   parameter int DATA_W = 1
) ();
   logic [NREQ-1:0]        req, we, lock, gnt, rvalid;
   logic [NREQ*ADDR_W-1:0] addr;
   logic [NREQ*DATA_W-1:0] wdata;
   logic [DATA_W-1:0]      rdata;
   modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
   modport slave (input req, we, addr, wdata, lock, output gnt, rvalid, rdata);
endinterface

// File: rtl/arr_port_arbiter.sv
// arr_port_arbiter: round-robin arbiter with bounded lock for one single-port array memory.
// Optional ARR_HOST_PRIORITY_EN gives requester 0 absolute priority and lets it break locks.
module arr_port_arbiter #(
   parameter int NREQ     = 2,
   parameter int ADDR_W   = 1,
   parameter int DATA_W   = 1,
   parameter int LOCK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   arr_port_if.slave         bus,
   output logic              arrWEnable,
   output logic [ADDR_W-1:0] arrAddr,
   output logic [DATA_W-1:0] arrWData,
   input  logic [DATA_W-1:0] arrRData,
   output logic              busy
);
   localparam int PW = $clog2(NREQ);
   localparam logic [3:0] CNT_LAST = 4'(LOCK_MAX - 1);
   typedef enum logic {UNLOCKED, LOCKED} state_t;
   state_t state, state_nx;
   logic [PW-1:0] rr_ptr, rr_nx, owner, owner_nx, win, idx;
   logic [3:0] cnt, cnt_nx;
   logic win_v, host;
   function automatic logic [PW-1:0] succ(input logic [PW-1:0] i);
      return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction
   always_comb begin
      win = rr_ptr;
      win_v = 1'b0;
      idx = '0;
      host = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(rr_ptr) + k) % NREQ);
         if (!win_v && bus.req[idx]) begin
            win_v = 1'b1;
            win = idx;
         end
      end
      if (state == LOCKED) begin
         win = owner;
         win_v = bus.req[owner];
      end
`ifdef ARR_HOST_PRIORITY_EN
      host = bus.req[0];
      if (host) begin
         win = '0;
         win_v = 1'b1;
      end
`endif
      // grant is suppressed asynchronously while reset is asserted
      win_v = win_v & rst_n;
      bus.gnt = win_v ? NREQ'(1) << win : '0;
      arrWEnable = win_v & bus.we[win];
      arrAddr = win_v ? bus.addr[win*ADDR_W +: ADDR_W] : 'x;
      arrWData = win_v ? bus.wdata[win*DATA_W +: DATA_W] : 'x;
      state_nx = state;
      owner_nx = owner;
      cnt_nx = cnt;
      rr_nx = rr_ptr;
      if (host) begin
         state_nx = UNLOCKED;
         cnt_nx = '0;
      end else if (state == LOCKED) begin
         if (bus.req[owner] && bus.lock[owner] && cnt < CNT_LAST) cnt_nx = cnt + 1'b1;
         else begin
            state_nx = UNLOCKED;
            cnt_nx = '0;
            rr_nx = succ(owner);
         end
      end else if (win_v) begin
         rr_nx = succ(win);
         if (bus.lock[win] && LOCK_MAX > 1) begin
            state_nx = LOCKED;
            owner_nx = win;
            cnt_nx = 4'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= UNLOCKED;
         owner <= '0;
         cnt <= '0;
         rr_ptr <= '0;
         bus.rvalid <= '0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         cnt <= cnt_nx;
         rr_ptr <= rr_nx;
         bus.rvalid <= bus.gnt & ~bus.we;
      end
   end
   assign bus.rdata = arrRData;
   assign busy = state == LOCKED;
endmodule

// File: tb/tb_arr_port_arbiter.sv
// tb_arr_port_arbiter: directed vectors into scoreboard queues, checked by a negedge monitor.
module tb_arr_port_arbiter;
   typedef struct {logic [1:0] g; logic b; logic wen; logic a;} gexp_t;
   typedef struct {int c; logic [1:0] v; logic d;} rexp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic arrWEnable, busy, rd_q;
   logic [0:0] arrAddr, arrWData;
   logic mem [2];
   logic ref_mem [2];
   int checks = 0, errors = 0, cyc_n = 0;
   gexp_t gq[$];
   rexp_t rq[$];
   gexp_t ge;
   rexp_t re;
   arr_port_if #(.NREQ(2), .ADDR_W(1), .DATA_W(1)) bus ();
   arr_port_arbiter #(.NREQ(2), .ADDR_W(1), .DATA_W(1), .LOCK_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .arrWEnable(arrWEnable), .arrAddr(arrAddr),
      .arrWData(arrWData), .arrRData(rd_q), .busy(busy));
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;
   // synchronous-read array the arbiter drives
   always @(posedge clk) begin
      if (arrWEnable) mem[arrAddr] <= arrWData;
      rd_q <= mem[arrAddr];
   end
   always @(negedge clk) begin
      if (gq.size() != 0) begin
         ge = gq.pop_front();
         checks++;
         if (bus.gnt !== ge.g || busy !== ge.b || arrWEnable !== ge.wen || (ge.g != 0 && arrAddr !== ge.a)) begin
            errors++;
            $display("FAIL grant cyc=%0d got gnt=%b busy=%b wen=%b addr=%b want gnt=%b busy=%b wen=%b addr=%b",
                     cyc_n, bus.gnt, busy, arrWEnable, arrAddr, ge.g, ge.b, ge.wen, ge.a);
         end
      end
      if (bus.rvalid != 0) begin
         checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got rvalid=%b want none", cyc_n, bus.rvalid);
         end else begin
            re = rq.pop_front();
            if (bus.rvalid !== re.v || bus.rdata !== re.d || cyc_n != re.c) begin
               errors++;
               $display("FAIL rvalid cyc=%0d got rvalid=%b rdata=%b want cyc=%0d rvalid=%b rdata=%b",
                        cyc_n, bus.rvalid, bus.rdata, re.c, re.v, re.d);
            end
         end
      end
   end
   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", name, act, exp);
      end
   endtask
   task automatic cyc(input logic [1:0] r, w, a, d, l, g, input logic b);
      int wi;
      @(posedge clk);
      #1;
      bus.req = r;
      bus.we = w;
      bus.addr = a;
      bus.wdata = d;
      bus.lock = l;
      wi = g[1] ? 1 : 0;
      gq.push_back('{g: g, b: b, wen: (g != 0) && w[wi], a: a[wi]});
      if (g != 0) begin
         if (w[wi]) ref_mem[a[wi]] = d[wi];
         else rq.push_back('{c: cyc_n + 1, v: g, d: ref_mem[a[wi]]});
      end
   endtask
   initial begin
      mem[0] = 1'b0;
      mem[1] = 1'b1;
      ref_mem[0] = 1'b0;
      ref_mem[1] = 1'b1;
      bus.req = '0;
      bus.we = '0;
      bus.addr = '0;
      bus.wdata = '0;
      bus.lock = '0;
      #2;
      chk("reset_gnt", bus.gnt, 2'b00);
      chk("reset_rvalid", bus.rvalid, 2'b00);
      chk("reset_busy", {1'b0, busy}, 2'b00);
      chk("reset_wen", {1'b0, arrWEnable}, 2'b00);
      #10 rst_n = 1'b1;
`ifndef ARR_HOST_PRIORITY_EN
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
      cyc(2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
      // forced release after LOCK_MAX grants
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0);
      cyc(2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0);
      cyc(2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
      cyc(2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
      void'(rq.pop_back());
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_gnt", bus.gnt, 2'b00);
      chk("async_rst_wen", {1'b0, arrWEnable}, 2'b00);
      bus.req = '0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0);
`else
      cyc(2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0);
      cyc(2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b1);
      cyc(2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
`endif
      cyc(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (gq.size() != 0 || rq.size() != 0) begin
         errors++;
         $display("FAIL drain got pending grant=%0d read=%0d want 0 0", gq.size(), rq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/arr_port_arbiter.md
Name: arr_port_arbiter

Overview:
- Shares one single-port array memory between NREQ requesters, e.g. the host control port and the generated FSM datapath.
- The memory has one access per cycle and a synchronous read: address registered at posedge, data valid the following cycle.
- Uses round-robin grant with an optional per-requester lock for multi-cycle bursts, bounded by a starvation counter.
- Sits between the requester address/data muxes and the arr_* memory instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 1, memory address width.
- DATA_W, 1, memory data width.
- LOCK_MAX, 4, maximum consecutive cycles one requester may hold the port under lock (1..15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester access request, level.
- we  in  NREQ  per-requester write enable, qualified by req.
- addr  in  NREQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*DATA_W  per-requester write data, packed the same way.
- lock  in  NREQ  hold ownership after the current grant.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the access.
- rvalid  out  NREQ  registered; read data valid for requester i.
- rdata  out  DATA_W  shared read data, equal to arrRData.
- arrWEnable  out  1  memory write enable.
- arrAddr  out  ADDR_W  memory address.
- arrWData  out  DATA_W  memory write data.
- arrRData  in  DATA_W  memory read data, one cycle after the read address.
- busy  out  1  registered; high while a lock is held.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n=0: gnt=0, arrWEnable=0, rvalid=0, busy=0, rr_ptr=0, owner invalid, lock_cnt=0.
- Arbitration (combinational, each cycle):
  - If an owner is locked, it is the only requester that can be granted.
  - Otherwise the winner is the first requester with req=1, searching from rr_ptr upward modulo NREQ.
  - No req asserted: gnt=0, arrWEnable=0, arrAddr/arrWData driven 'x.
- Memory drive: arrAddr/arrWData/arrWEnable take the winner's addr/wdata/we in the grant cycle. The winner therefore sees its access complete in the same cycle gnt is high.
- Read return:
  - A granted read (we=0) sets rvalid[winner]=1 in the next cycle only.
  - rdata = arrRData in that cycle.
  - Granted writes never raise rvalid.
- Round-robin update: on any unlocked grant to i, rr_ptr <= (i+1) mod NREQ.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED: the winner has lock=1 and LOCK_MAX>1. The owner is recorded and lock_cnt <= 1.
  - In LOCKED, each cycle the owner has req=1 and lock=1 and lock_cnt<LOCK_MAX-1: stay in LOCKED, grant the owner, increment lock_cnt.
  - LOCKED -> UNLOCKED: the owner drops lock or req, or lock_cnt reaches LOCK_MAX-1 (forced release).
    - The releasing cycle itself is still granted to the owner if it has req=1.
    - rr_ptr <= owner+1.
  - While LOCKED, req from other requesters is ignored, not queued; they must hold req.
  - busy = (state==LOCKED).
- Boundaries:
  - Write followed by a read of the same address in the next cycle returns the new data.
  - Back-to-back reads from different requesters return rvalid on consecutive cycles, each to the correct requester.
  - An async reset between a read grant and its return suppresses rvalid.

Optional Feature:
- Macro: ARR_HOST_PRIORITY_EN.
- Defined: requester 0 (host control port) has absolute priority.
  - When req[0]=1 it wins regardless of rr_ptr or lock.
  - An existing lock held by another requester is broken: state -> UNLOCKED, lock_cnt=0.
  - rr_ptr is not updated on requester-0 grants.
- Undefined: requester 0 is arbitrated round-robin like the others.

Test Plan:
- Reset, then req=2'b11 with we=00 and addr0=0, addr1=1 for two cycles -> gnt=01 then 10; rvalid=01 then 10 one cycle after each grant, with rdata = mem[0] then mem[1].
- Requester 1 writes wdata=1 to addr 0, then requester 0 reads addr 0 the next cycle -> gnt0 and arrAddr=0 in that cycle; rvalid[0]=1 with rdata=1 one cycle later.
- LOCK_MAX=4: requester 1 holds lock=1 and req=1 while requester 0 holds req=1 -> gnt=10 for exactly 4 cycles, busy=1 for 3 cycles, then gnt=01.
- Requester 1 locks and drops lock after 2 cycles -> busy falls the next cycle; requester 0 is granted in the following cycle.
- Assert rst_n=0 for one cycle immediately after a read grant -> rvalid stays 0, gnt=0 asynchronously, and after reset the first grant goes to requester 0.
- With ARR_HOST_PRIORITY_EN: requester 1 locked, then req[0]=1 -> gnt=01 that cycle and busy=0 the next cycle.
